// File: rtl/multicycle_maindec.sv
// rtl/multicycle_maindec.sv - multicycle MIPS64 main decoder FSM (optional MAINDEC_PERF_EN perf counters)
module multicycle_maindec #(
  parameter int XLEN        = 64,
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memread,
  output logic [1:0] memwrite,
  output logic [2:0] readtype,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] aluop,
  output logic       trap,
  output logic [3:0] state_o
`ifdef MAINDEC_PERF_EN
  ,output logic [31:0] instret,
  output logic [31:0] stallcyc
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010,
                         OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101,
                         OP_ADDI  = 6'b001000, OP_SLTI = 6'b001010,
                         OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101,
                         OP_DADDI = 6'b011000, OP_LB   = 6'b100000,
                         OP_LW    = 6'b100011, OP_LBU  = 6'b100100,
                         OP_LWU   = 6'b100111, OP_SB   = 6'b101000,
                         OP_SW    = 6'b101011, OP_LD   = 6'b110111,
                         OP_SD    = 6'b111111;

  localparam logic [TW-1:0] TO_LIM = TW'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
    MEMWB = 4'd4, MEMWR = 4'd5, RTEXEC = 4'd6, IMMEXEC = 4'd7,
    ALUWB = 4'd8, BRANCH = 4'd9, JUMP = 4'd10, TRAP = 4'd11
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] cnt;
  logic          is_load, is_store, is_imm, xlen_bad;
  logic          wait_state, timeout_hit, cnt_inc;
  logic          irwrite_c, pcen_c, regwrite_c, memread_c;
  logic [1:0]    memwrite_c;

  // Opcode classes; on a 32-bit datapath the doubleword ops decode as illegal
  always_comb begin
    is_load  = (op == OP_LW) || (op == OP_LWU) || (op == OP_LB) ||
               (op == OP_LBU) || (op == OP_LD);
    is_store = (op == OP_SW) || (op == OP_SB) || (op == OP_SD);
    is_imm   = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
               (op == OP_SLTI) || (op == OP_DADDI);
    xlen_bad = (XLEN == 32) &&
               ((op == OP_LD) || (op == OP_SD) || (op == OP_LWU) || (op == OP_DADDI));
  end

  // Memory-wait bookkeeping: a ready in the limit cycle beats the timeout
  always_comb begin
    wait_state  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    timeout_hit = (MEM_TIMEOUT > 0) && wait_state && !mem_ready && (cnt == TO_LIM);
    cnt_inc     = wait_state && !mem_ready && !timeout_hit;
  end

  // State register and wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state) cnt <= '0;
      else if (cnt_inc)     cnt <= cnt + 1'b1;
    end
  end

  // Next-state and per-state control outputs
  always_comb begin
    state_n    = state;
    memread_c  = 1'b0;
    memwrite_c = 2'b00;
    readtype   = 3'b000;
    iord       = 1'b0;
    irwrite_c  = 1'b0;
    pcen_c     = 1'b0;
    pcsrc      = 2'b00;
    regwrite_c = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 3'b000;
    unique case (state)
      FETCH: begin
        memread_c = 1'b1;
        alusrcb   = 2'b01;
        irwrite_c = mem_ready;
        pcen_c    = mem_ready;
        if (mem_ready)        state_n = DECODE;
        else if (timeout_hit) state_n = TRAP;
      end
      DECODE: begin
        alusrcb = 2'b10;
        if (xlen_bad)                          state_n = TRAP;
        else if (is_load || is_store)          state_n = MEMADR;
        else if (op == OP_RTYPE)               state_n = RTEXEC;
        else if (is_imm)                       state_n = IMMEXEC;
        else if (op == OP_BEQ || op == OP_BNE) state_n = BRANCH;
        else if (op == OP_J)                   state_n = JUMP;
        else                                   state_n = TRAP;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 3'b100;
        state_n = is_load ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memread_c = 1'b1;
        iord      = 1'b1;
        case (op)
          OP_LWU:  readtype = 3'b001;
          OP_LB:   readtype = 3'b010;
          OP_LBU:  readtype = 3'b011;
          OP_LD:   readtype = 3'b100;
          default: readtype = 3'b000;
        endcase
        if (mem_ready)        state_n = MEMWB;
        else if (timeout_hit) state_n = TRAP;
      end
      MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg   = 1'b1;
        state_n    = FETCH;
      end
      MEMWR: begin
        iord = 1'b1;
        case (op)
          OP_SD:   memwrite_c = 2'b11;
          OP_SB:   memwrite_c = 2'b10;
          default: memwrite_c = 2'b01;
        endcase
        if (mem_ready)        state_n = FETCH;
        else if (timeout_hit) state_n = TRAP;
      end
      RTEXEC: begin
        alusrca = 1'b1;
        aluop   = 3'b111;
        state_n = ALUWB;
      end
      IMMEXEC: begin
        alusrca = 1'b1;
        alusrcb = (op == OP_ANDI || op == OP_ORI) ? 2'b11 : 2'b10;
        case (op)
          OP_ANDI:  aluop = 3'b001;
          OP_ORI:   aluop = 3'b010;
          OP_SLTI:  aluop = 3'b011;
          OP_DADDI: aluop = 3'b100;
          default:  aluop = 3'b000;
        endcase
        state_n = ALUWB;
      end
      ALUWB: begin
        regwrite_c = 1'b1;
        regdst     = (op == OP_RTYPE);
        state_n    = FETCH;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 3'b110;
        pcsrc   = 2'b01;
        pcen_c  = (op == OP_BNE) ? !zero : zero;
        state_n = FETCH;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcen_c  = 1'b1;
        state_n = FETCH;
      end
      TRAP:    state_n = TRAP;
      default: state_n = TRAP;
    endcase
  end

  // Reset gates every strobe and the read request without waiting for a clock
  always_comb begin
    irwrite  = irwrite_c & reset;
    pcen     = pcen_c & reset;
    regwrite = regwrite_c & reset;
    memwrite = memwrite_c & {2{reset}};
    memread  = memread_c & reset;
    trap     = (state == TRAP);
    state_o  = state;
  end

`ifdef MAINDEC_PERF_EN
  // Retired-instruction and memory-stall counters, free-running with wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret  <= '0;
      stallcyc <= '0;
    end else begin
      if (state_n == FETCH && (state == MEMWB || state == ALUWB || state == BRANCH ||
                               state == JUMP || state == MEMWR))
        instret <= instret + 32'd1;
      if (cnt_inc) stallcyc <= stallcyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_maindec.sv
// tb/tb_multicycle_maindec.sv - self-checking bench for multicycle_maindec
module tb_multicycle_maindec;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J   = 6'b000010, OP_BEQ  = 6'b000100,
                         OP_BNE   = 6'b000101, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010,
                         OP_ANDI  = 6'b001100, OP_ORI = 6'b001101, OP_DADDI = 6'b011000,
                         OP_LB    = 6'b100000, OP_LW  = 6'b100011, OP_SB   = 6'b101000,
                         OP_SW    = 6'b101011, OP_LD  = 6'b110111, OP_SD   = 6'b111111;

  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] op = 6'd0;

  logic       memread, iord, irwrite, pcen, regwrite, regdst, memtoreg, alusrca, trap;
  logic [1:0] memwrite, pcsrc, alusrcb;
  logic [2:0] readtype, aluop;
  logic [3:0] state_o;

  logic       memread32, iord32, irwrite32, pcen32, regwrite32, regdst32, memtoreg32, alusrca32, trap32;
  logic [1:0] memwrite32, pcsrc32, alusrcb32;
  logic [2:0] readtype32, aluop32;
  logic [3:0] state32;

  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  multicycle_maindec dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .memread(memread), .memwrite(memwrite), .readtype(readtype), .iord(iord),
    .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .trap(trap), .state_o(state_o)
  );

  multicycle_maindec #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .memread(memread32), .memwrite(memwrite32), .readtype(readtype32), .iord(iord32),
    .irwrite(irwrite32), .pcen(pcen32), .pcsrc(pcsrc32), .regwrite(regwrite32),
    .regdst(regdst32), .memtoreg(memtoreg32), .alusrca(alusrca32), .alusrcb(alusrcb32),
    .aluop(aluop32), .trap(trap32), .state_o(state32)
  );

  typedef struct {
    logic [5:0] op;
    logic       zero;
    int         lat;
    logic [3:0] st2;
    logic [2:0] alu2;
    logic [1:0] srcb2;
    logic       reg_w, dst, m2r, pc_en;
    logic [1:0] pc_src, mw;
    logic       trp;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic [5:0] o, input logic z, input int lat, input logic [3:0] st2,
                         input logic [2:0] alu2, input logic [1:0] srcb2, input logic rw,
                         input logic dst, input logic m2r, input logic pe,
                         input logic [1:0] ps, input logic [1:0] mw);
    vec_t v;
    v.op = o; v.zero = z; v.lat = lat; v.st2 = st2; v.alu2 = alu2; v.srcb2 = srcb2;
    v.reg_w = rw; v.dst = dst; v.m2r = m2r; v.pc_en = pe; v.pc_src = ps; v.mw = mw; v.trp = 1'b0;
    vecs.push_back(v);
  endtask

  // Runs one instruction with mem_ready=1 from FETCH back to FETCH, recording key samples
  task automatic run_instr(input logic [5:0] o, input logic z, output vec_t ob);
    ob.op = o; ob.zero = z; ob.lat = 99; ob.st2 = 4'hf; ob.alu2 = 3'd0; ob.srcb2 = 2'd0;
    ob.reg_w = 1'b0; ob.dst = 1'b0; ob.m2r = 1'b0; ob.pc_en = 1'b0; ob.pc_src = 2'd0;
    ob.mw = 2'd0; ob.trp = 1'b1;
    op = o; zero = z; mem_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0 && state_o == 4'd0) begin
        ob.lat = cyc;
        ob.trp = trap;
        break;
      end
      if (cyc == 2) begin ob.st2 = state_o; ob.alu2 = aluop; ob.srcb2 = alusrcb; end
      ob.reg_w = regwrite; ob.dst = regdst; ob.m2r = memtoreg; ob.pc_en = pcen;
      ob.pc_src = pcsrc; ob.mw = memwrite;
      @(negedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    vec_t obs, e;
    logic mr_sched [8];
    logic [3:0] st_sched [8];

    add_vec(OP_RTYPE, 0, 4, 4'd6, 3'b111, 2'b00, 1, 1, 0, 0, 2'b00, 2'b00);
    add_vec(OP_ADDI,  0, 4, 4'd7, 3'b000, 2'b10, 1, 0, 0, 0, 2'b00, 2'b00);
    add_vec(OP_ANDI,  0, 4, 4'd7, 3'b001, 2'b11, 1, 0, 0, 0, 2'b00, 2'b00);
    add_vec(OP_ORI,   0, 4, 4'd7, 3'b010, 2'b11, 1, 0, 0, 0, 2'b00, 2'b00);
    add_vec(OP_SLTI,  0, 4, 4'd7, 3'b011, 2'b10, 1, 0, 0, 0, 2'b00, 2'b00);
    add_vec(OP_DADDI, 0, 4, 4'd7, 3'b100, 2'b10, 1, 0, 0, 0, 2'b00, 2'b00);
    add_vec(OP_LW,    0, 5, 4'd2, 3'b100, 2'b10, 1, 0, 1, 0, 2'b00, 2'b00);
    add_vec(OP_LD,    0, 5, 4'd2, 3'b100, 2'b10, 1, 0, 1, 0, 2'b00, 2'b00);
    add_vec(OP_SW,    0, 4, 4'd2, 3'b100, 2'b10, 0, 0, 0, 0, 2'b00, 2'b01);
    add_vec(OP_SB,    0, 4, 4'd2, 3'b100, 2'b10, 0, 0, 0, 0, 2'b00, 2'b10);
    add_vec(OP_SD,    0, 4, 4'd2, 3'b100, 2'b10, 0, 0, 0, 0, 2'b00, 2'b11);
    add_vec(OP_BEQ,   1, 3, 4'd9, 3'b110, 2'b00, 0, 0, 0, 1, 2'b01, 2'b00);
    add_vec(OP_BEQ,   0, 3, 4'd9, 3'b110, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00);
    add_vec(OP_BNE,   0, 3, 4'd9, 3'b110, 2'b00, 0, 0, 0, 1, 2'b01, 2'b00);
    add_vec(OP_BNE,   1, 3, 4'd9, 3'b110, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00);
    add_vec(OP_J,     0, 3, 4'd10, 3'b000, 2'b00, 0, 0, 0, 1, 2'b10, 2'b00);

    // Reset state with mem_ready high: strobes must stay low
    #2 reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_state", state_o, 4'd0);
    chk("rst_trap", trap, 1'b0);
    chk("rst_irwrite", irwrite, 1'b0);
    chk("rst_pcen", pcen, 1'b0);
    chk("rst_memread", memread, 1'b0);
    chk("rst_memwrite", memwrite, 2'b00);
    chk("rst_state32", state32, 4'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table: scoreboard pushes expectations as each instruction is driven
    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back(vecs[i]);
      run_instr(vecs[i].op, vecs[i].zero, obs);
      e = exp_q.pop_front();
      chk($sformatf("v%0d_lat", i), obs.lat, e.lat);
      chk($sformatf("v%0d_st2", i), obs.st2, e.st2);
      chk($sformatf("v%0d_aluop", i), obs.alu2, e.alu2);
      chk($sformatf("v%0d_alusrcb", i), obs.srcb2, e.srcb2);
      chk($sformatf("v%0d_regwrite", i), obs.reg_w, e.reg_w);
      chk($sformatf("v%0d_regdst", i), obs.dst, e.dst);
      chk($sformatf("v%0d_memtoreg", i), obs.m2r, e.m2r);
      chk($sformatf("v%0d_pcen", i), obs.pc_en, e.pc_en);
      chk($sformatf("v%0d_pcsrc", i), obs.pc_src, e.pc_src);
      chk($sformatf("v%0d_memwrite", i), obs.mw, e.mw);
      chk($sformatf("v%0d_trap", i), obs.trp, e.trp);
    end

    // LB with three wait cycles in MEMRD
    do_reset();
    mr_sched = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    st_sched = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    op = OP_LB;
    for (int c = 0; c < 8; c++) begin
      mem_ready = mr_sched[c];
      #1;
      chk($sformatf("lb_state_c%0d", c), state_o, st_sched[c]);
      if (c >= 3 && c <= 6) begin
        chk($sformatf("lb_memread_c%0d", c), memread, 1'b1);
        chk($sformatf("lb_iord_c%0d", c), iord, 1'b1);
        chk($sformatf("lb_readtype_c%0d", c), readtype, 3'b010);
      end
      if (c == 7) begin
        chk("lb_memtoreg", memtoreg, 1'b1);
        chk("lb_regwrite", regwrite, 1'b1);
      end
      @(negedge clk);
    end
    #1 chk("lb_back_fetch", state_o, 4'd0);

    // XLEN=32 traps on LD, 64-bit instance proceeds
    do_reset();
    op = OP_LD; mem_ready = 1'b1;
    @(negedge clk); #1 chk("x32_decode", state32, 4'd1);
    @(negedge clk); #1;
    chk("x32_state_trap", state32, 4'd11);
    chk("x32_trap", trap32, 1'b1);
    chk("x64_memadr", state_o, 4'd2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk($sformatf("x32_trap_hold%0d", k), trap32, 1'b1);
    end
    reset = 1'b0;
    #1;
    chk("x32_rst_state", state32, 4'd0);
    chk("x32_rst_trap", trap32, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Unknown opcode on the 64-bit instance
    do_reset();
    op = 6'b111000; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("illegal_state", state_o, 4'd11);
    chk("illegal_trap", trap, 1'b1);
    chk("illegal_regwrite", regwrite, 1'b0);

    // Fetch timeout: trap after 16 cycles without ready
    mem_ready = 1'b0; op = OP_RTYPE;
    do_reset();
    for (int k = 0; k < 15; k++) @(negedge clk);
    #1;
    chk("to_15_state", state_o, 4'd0);
    chk("to_15_trap", trap, 1'b0);
    @(negedge clk); #1;
    chk("to_16_state", state_o, 4'd11);
    chk("to_16_trap", trap, 1'b1);

    // Ready in the limit cycle wins over the timeout
    mem_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 15; k++) @(negedge clk);
    mem_ready = 1'b1;
    #1 chk("to_ready_irwrite", irwrite, 1'b1);
    @(negedge clk); #1;
    chk("to_ready_state", state_o, 4'd1);
    chk("to_ready_trap", trap, 1'b0);

    // SD, then asynchronous reset inside MEMWR
    mem_ready = 1'b1;
    do_reset();
    op = OP_SD;
    @(negedge clk); @(negedge clk); @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("sd_state", state_o, 4'd5);
    chk("sd_memwrite", memwrite, 2'b11);
    chk("sd_iord", iord, 1'b1);
    @(negedge clk); #1;
    chk("sd_hold", memwrite, 2'b11);
    #1 reset = 1'b0;
    #1;
    chk("sd_rst_memwrite", memwrite, 2'b00);
    chk("sd_rst_memread", memread, 1'b0);
    chk("sd_rst_state", state_o, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
